// File: rtl/trace_trig_sequencer_pkg.sv
// Shared encodings and widths for the ArmTrace trigger sequencer.
// The register block decodes O_state with these same enums.
package trace_trig_sequencer_pkg;

   localparam int TSEQ_MATCH_RULES  = 8;
   localparam int TSEQ_NUM_STAGES   = 4;
   localparam int TSEQ_WINDOW_WIDTH = 16;
   localparam int TSEQ_STAGE_BITS   = $clog2(TSEQ_NUM_STAGES);

   typedef enum logic [1:0] {
      TSEQ_IDLE = 2'd0,
      TSEQ_WAIT = 2'd1,
      TSEQ_FIRE = 2'd2,
      TSEQ_DONE = 2'd3
   } tseq_state_e;

   function automatic logic [7:0] tseq_sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/trace_seq_window_timer.sv
// Per-stage gap window: load W, count down, flag the last legal cycle.
// A zero count means the window is disabled.
module trace_seq_window_timer
   import trace_trig_sequencer_pkg::*;
#(
   parameter int pWINDOW_WIDTH = TSEQ_WINDOW_WIDTH
) (
   input  logic                     trace_clk,
   input  logic                     reset_i,
   input  logic                     clear,
   input  logic                     load,
   input  logic [pWINDOW_WIDTH-1:0] load_val,
   output logic                     expire
);

   logic [pWINDOW_WIDTH-1:0] cnt_q;

   always_ff @(posedge trace_clk) begin
      if (reset_i || clear) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Count of 1 marks cycle n+W, the last cycle a hit is still accepted.
   assign expire = (cnt_q == pWINDOW_WIDTH'(1));

endmodule

// File: rtl/trace_trig_sequencer.sv
// Multi-stage trigger sequencer: ordered rule hits with per-stage gap
// windows, firing a programmable-length trigger pulse.
module trace_trig_sequencer
   import trace_trig_sequencer_pkg::*;
#(
   parameter  int pMATCH_RULES  = TSEQ_MATCH_RULES,
   parameter  int pNUM_STAGES   = TSEQ_NUM_STAGES,
   parameter  int pWINDOW_WIDTH = TSEQ_WINDOW_WIDTH,
   localparam int pSTAGE_BITS   = $clog2(pNUM_STAGES)
) (
   input  logic                                 trace_clk,
   input  logic                                 reset_i,
   input  logic                                 I_arm,
   input  logic                                 I_abort,
   input  logic [pSTAGE_BITS-1:0]               I_num_stages,
   input  logic [pNUM_STAGES*pMATCH_RULES-1:0]  I_stage_rules,
   input  logic [pNUM_STAGES*pWINDOW_WIDTH-1:0] I_stage_window,
   input  logic [7:0]                           I_pulse_len,
   input  logic [pMATCH_RULES-1:0]              I_match,
   output logic                                 O_trigger,
   output logic [1:0]                           O_state,
   output logic [pSTAGE_BITS-1:0]               O_stage,
   output logic                                 O_done,
   output logic [7:0]                           O_timeout_count
);

   logic [pNUM_STAGES-1:0][pMATCH_RULES-1:0]  rules_sh;
   logic [pNUM_STAGES-1:0][pWINDOW_WIDTH-1:0] window_sh;
   logic [pSTAGE_BITS-1:0]                    num_sh;
   logic [7:0]                                plen_sh;

   tseq_state_e            state_q, state_d;
   logic [pSTAGE_BITS-1:0] stage_q, stage_d, stage_nx;
   logic                   done_q, done_d;
   logic [7:0]             tcnt_q, tcnt_d;
   logic [7:0]             pcnt_q, pcnt_d;
   logic                   trig_q;
   logic                   arm_q;
   logic                   arm_rise;
   logic                   hit;
   logic                   shadow_ld;
   logic                   tmr_clear;
   logic                   tmr_load;
   logic                   tmr_expire;

   assign arm_rise = I_arm & ~arm_q;
   assign stage_nx = stage_q + pSTAGE_BITS'(1);
   assign hit      = |(I_match & rules_sh[stage_q]);

   trace_seq_window_timer #(
      .pWINDOW_WIDTH (pWINDOW_WIDTH)
   ) u_window (
      .trace_clk (trace_clk),
      .reset_i   (reset_i),
      .clear     (tmr_clear),
      .load      (tmr_load),
      .load_val  (window_sh[stage_nx]),
      .expire    (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      done_d    = done_q;
      tcnt_d    = tcnt_q;
      pcnt_d    = pcnt_q;
      shadow_ld = 1'b0;
      tmr_clear = 1'b0;
      tmr_load  = 1'b0;
      if (I_abort) begin
         state_d   = TSEQ_IDLE;
         stage_d   = '0;
         pcnt_d    = '0;
         tmr_clear = 1'b1;
      end else if (arm_rise) begin
         state_d   = TSEQ_WAIT;
         stage_d   = '0;
         done_d    = 1'b0;
         tcnt_d    = '0;
         pcnt_d    = '0;
         shadow_ld = 1'b1;
         tmr_clear = 1'b1;
      end else begin
         case (state_q)
            TSEQ_WAIT: begin
               if (hit && (stage_q < num_sh)) begin
                  stage_d  = stage_nx;
                  tmr_load = 1'b1;
               end else if (hit) begin
                  state_d   = TSEQ_FIRE;
                  pcnt_d    = (plen_sh == 8'd0) ? 8'd1 : plen_sh;
                  tmr_clear = 1'b1;
               end else if (tmr_expire) begin
                  stage_d   = '0;
                  tcnt_d    = tseq_sat_inc(tcnt_q);
                  tmr_clear = 1'b1;
               end
            end
            TSEQ_FIRE: begin
               if (pcnt_q <= 8'd1) begin
                  state_d = TSEQ_DONE;
                  done_d  = 1'b1;
                  pcnt_d  = '0;
               end else begin
                  pcnt_d = pcnt_q - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Edge detector tracks I_arm through reset so a held-high arm stays inert.
   always_ff @(posedge trace_clk) begin
      arm_q <= I_arm;
   end

   always_ff @(posedge trace_clk) begin
      if (reset_i) begin
         state_q <= TSEQ_IDLE;
         stage_q <= '0;
         done_q  <= 1'b0;
         tcnt_q  <= '0;
         pcnt_q  <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         done_q  <= done_d;
         tcnt_q  <= tcnt_d;
         pcnt_q  <= pcnt_d;
         trig_q  <= (state_d == TSEQ_FIRE);
      end
   end

   always_ff @(posedge trace_clk) begin
      if (reset_i) begin
         rules_sh  <= '0;
         window_sh <= '0;
         num_sh    <= '0;
         plen_sh   <= '0;
      end else if (shadow_ld) begin
         rules_sh  <= I_stage_rules;
         window_sh <= I_stage_window;
         num_sh    <= I_num_stages;
         plen_sh   <= I_pulse_len;
      end
   end

   assign O_trigger       = trig_q;
   assign O_state         = state_q;
   assign O_stage         = stage_q;
   assign O_done          = done_q;
   assign O_timeout_count = tcnt_q;

endmodule

// File: tb/tb_trace_trig_sequencer.sv
// Self-checking bench for trace_trig_sequencer: vector table, directed
// corner sequences, and random traffic against a timestamp-based model.
module tb_trace_trig_sequencer;
   import trace_trig_sequencer_pkg::*;

   logic        clk;
   logic        rst;
   logic        arm;
   logic        abort;
   logic [1:0]  nst;
   logic [31:0] rules;
   logic [63:0] win;
   logic [7:0]  plen;
   logic [7:0]  match;
   logic        trig;
   logic [1:0]  state;
   logic [TSEQ_STAGE_BITS-1:0] stage;
   logic        done;
   logic [7:0]  tcnt;

   int n_pass  = 0;
   int n_total = 0;
   longint cyc = 0;

   // reference model state, timestamps in absolute cycles
   int          m_state;
   int          m_stage;
   bit          m_done;
   int          m_tcnt;
   longint      m_deadline;
   longint      m_fire_end;
   bit          m_parm;
   int          c_num;
   logic [31:0] c_rules;
   logic [63:0] c_win;
   int          c_len;

   trace_trig_sequencer dut (
      .trace_clk       (clk),
      .reset_i         (rst),
      .I_arm           (arm),
      .I_abort         (abort),
      .I_num_stages    (nst),
      .I_stage_rules   (rules),
      .I_stage_window  (win),
      .I_pulse_len     (plen),
      .I_match         (match),
      .O_trigger       (trig),
      .O_state         (state),
      .O_stage         (stage),
      .O_done          (done),
      .O_timeout_count (tcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic model_step();
      bit          rise;
      logic [7:0]  rm;
      int          w;
      if (rst) begin
         m_state = 0; m_stage = 0; m_done = 0; m_tcnt = 0;
         m_deadline = -1; m_parm = arm;
         return;
      end
      rise = arm && !m_parm;
      m_parm = arm;
      if (abort) begin
         m_state = 0; m_stage = 0;
      end else if (rise) begin
         c_num = int'(nst); c_rules = rules; c_win = win;
         c_len = (plen == 0) ? 1 : int'(plen);
         m_state = 1; m_stage = 0; m_done = 0; m_tcnt = 0;
         m_deadline = -1;
      end else if (m_state == 1) begin
         rm = c_rules[m_stage*8 +: 8];
         if ((match & rm) != 0) begin
            if (m_stage < c_num) begin
               m_stage++;
               w = int'(c_win[m_stage*16 +: 16]);
               m_deadline = (w == 0) ? -1 : cyc + w;
            end else begin
               m_state = 2;
               m_fire_end = cyc + c_len;
            end
         end else if (m_deadline >= 0 && cyc == m_deadline) begin
            m_stage = 0;
            m_deadline = -1;
            if (m_tcnt < 255) m_tcnt++;
         end
      end else if (m_state == 2) begin
         if (cyc + 1 > m_fire_end) begin
            m_state = 3; m_done = 1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      logic       arm;
      logic       abort;
      logic [7:0] match;
      logic [1:0] st;
      logic [1:0] sg;
      logic       tr;
      logic       dn;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h08, 2'd1, 2'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h04, 2'd2, 2'd0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 8'h04, 2'd2, 2'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 2'd2, 2'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 2'd3, 2'd0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 8'h04, 2'd3, 2'd0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8'h04, 2'd2, 2'd0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 2'd1, 2'd0, 1'b0, 1'b0};

      rst = 1'b1; arm = 1'b1; abort = 1'b0; nst = '0;
      rules = '0; win = '0; plen = '0; match = '0;
      m_parm = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", {trig, state, stage, done, tcnt}, 32'h0);
      rst = 1'b0;
      tick();
      chk("arm_high_thru_reset", {state, trig}, {TSEQ_IDLE, 1'b0});
      tick();
      chk("arm_high_still_idle", state, TSEQ_IDLE);
      arm = 1'b0;
      tick();

      // single-stage sequence, FIRE/DONE, re-arm, abort and abort+arm
      nst = 2'd0; rules = 32'h0000_0004; plen = 8'd3;
      for (int i = 0; i < 16; i++) begin
         arm = tbl[i].arm; abort = tbl[i].abort; match = tbl[i].match;
         tick();
         chk($sformatf("tbl%0d", i), {trig, state, stage, done},
             {tbl[i].tr, tbl[i].st, tbl[i].sg, tbl[i].dn});
      end
      arm = 1'b0; abort = 1'b1; match = '0;
      tick();
      abort = 1'b0;

      // two stages, hit on the last window cycle
      nst = 2'd1; rules = 32'h0000_0201;
      win = 64'h0000_0000_0005_0000; plen = 8'd1;
      arm = 1'b1; tick(); arm = 1'b0;
      match = 8'h01; tick();
      chk("t2_stage1", stage, 1);
      match = 8'h00; repeat (4) tick();
      match = 8'h02; tick();
      chk("t2_trig_n6", {trig, state}, {1'b1, TSEQ_FIRE});
      match = 8'h00; tick();
      chk("t2_done", {trig, state, done}, {1'b0, TSEQ_DONE, 1'b1});

      // same config, window expires
      arm = 1'b1; tick(); arm = 1'b0;
      chk("t2_rearm", {state, done, tcnt}, {TSEQ_WAIT, 1'b0, 8'd0});
      match = 8'h01; tick();
      match = 8'h00; repeat (4) tick();
      chk("t2_last_cycle", stage, 1);
      tick();
      chk("t2_expired", {state, stage, tcnt}, {TSEQ_WAIT, 2'd0, 8'd1});
      match = 8'h02; tick();
      chk("t2_no_trig", {trig, state, stage}, {1'b0, TSEQ_WAIT, 2'd0});
      match = 8'h00;

      // unlimited window, one advance per cycle
      win = '0;
      arm = 1'b1; tick(); arm = 1'b0;
      match = 8'h03; tick();
      chk("t3_one_adv", {trig, state, stage}, {1'b0, TSEQ_WAIT, 2'd1});
      match = 8'h00; repeat (20) tick();
      chk("t3_no_timeout", {stage, tcnt}, {2'd1, 8'd0});
      match = 8'h02; tick();
      chk("t3_trig", trig, 1);
      match = 8'h00;

      // shadowed config, pulse_len 0, abort in DONE
      nst = 2'd0; rules = 32'h0000_0010; plen = 8'd0;
      arm = 1'b1; tick(); arm = 1'b0;
      rules = 32'h0000_0020; plen = 8'd5; nst = 2'd1;
      match = 8'h20; tick();
      chk("t5_new_rule_ign", {trig, state, stage}, {1'b0, TSEQ_WAIT, 2'd0});
      match = 8'h10; tick();
      chk("t5_old_rule", {trig, state}, {1'b1, TSEQ_FIRE});
      match = 8'h00; tick();
      chk("t5_one_cycle", {trig, state, done}, {1'b0, TSEQ_DONE, 1'b1});
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t4_abort_done", {state, done}, {TSEQ_IDLE, 1'b1});
      tick();
      chk("t4_stay_idle", state, TSEQ_IDLE);

      // saturating timeouts
      nst = 2'd1; rules = 32'h0000_0201;
      win = 64'h0000_0000_0001_0000; plen = 8'd4;
      arm = 1'b1; tick(); arm = 1'b0;
      for (int i = 0; i < 300; i++) begin
         match = 8'h01; tick();
         match = 8'h00; tick();
         if (i == 254) chk("t6_tcnt_255", tcnt, 8'd255);
      end
      chk("t6_tcnt_sat", tcnt, 8'd255);
      match = 8'h01; tick();
      match = 8'h02; tick();
      chk("t4_fire", {trig, state}, {1'b1, TSEQ_FIRE});
      match = 8'h00; abort = 1'b1; tick(); abort = 1'b0;
      chk("t4_abort_fire", {trig, state, stage, done, tcnt},
          {1'b0, TSEQ_IDLE, 2'd0, 1'b0, 8'd255});
      arm = 1'b1; tick(); arm = 1'b0;
      match = 8'h01; tick(); match = 8'h00;
      chk("t6_pre_reset", {state, stage}, {TSEQ_WAIT, 2'd1});
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_reset_wait", {trig, state, stage, done, tcnt}, 32'h0);

      // random traffic vs model
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 50 == 0) begin
            nst = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
               int r;
               logic [7:0] m;
               r = $urandom_range(0, 5);
               m = 8'(1 << $urandom_range(0, 7));
               if (r > 3) m = m | 8'(1 << $urandom_range(0, 7));
               if (r == 0) m = '0;
               rules[k*8 +: 8] = m;
               win[k*16 +: 16] = 16'($urandom_range(0, 8));
            end
            plen = 8'($urandom_range(0, 4));
         end
         rst   = ($urandom_range(0, 199) == 0);
         abort = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 24) == 0) arm = ~arm;
         match = ($urandom_range(0, 1) == 0) ? 8'h00 :
                 8'($urandom_range(0, 255) & $urandom_range(0, 255));
         tick();
         chk($sformatf("rnd%0d", i), {trig, state, stage, done, tcnt},
             {(m_state == 2), 2'(m_state), 2'(m_stage), m_done,
              8'(m_tcnt)});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
